// File: rtl/cdc_frame_rx_pkg.sv
// cdc_pkg: shared frame types and defaults for the CDC framer pair.
// No ports; imported by the receive path and the future transmit framer.
package cdc_pkg;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM
  } frx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CSUM,
    ERR_LEN,
    ERR_TMO
  } frx_err_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MAX_LEN_DEF   = 64;
  localparam int         TIMEOUT_DEF   = 255;

endpackage

// File: rtl/cdc_frame_rx_if.sv
// cdc_frame_rx_if: byte stream in, payload/status/stats out.
// master = stream source and consumer; slave = the receiver.
interface cdc_frame_rx_if #(
  parameter int WIDTH = 8
);

  logic             data_valid_b;
  logic [WIDTH-1:0] data_b;
  logic             pld_valid;
  logic [WIDTH-1:0] pld_data;
  logic             pld_first;
  logic             pld_last;
  logic             frame_done;
  logic             frame_ok;
  logic [1:0]       frame_err;
  logic [15:0]      frame_cnt;
  logic [15:0]      err_cnt;

  modport master (
    output data_valid_b, data_b,
    input  pld_valid, pld_data,
    input  pld_first, pld_last,
    input  frame_done, frame_ok,
    input  frame_err,
    input  frame_cnt, err_cnt
  );

  modport slave (
    input  data_valid_b, data_b,
    output pld_valid, pld_data,
    output pld_first, pld_last,
    output frame_done, frame_ok,
    output frame_err,
    output frame_cnt, err_cnt
  );

endinterface

// File: rtl/cdc_frame_rx_stats.sv
// frx_stats: accepted-frame count (wraps) and rejected count (saturates).
// Ports: clk_b, rst_n, inc_ok_i, inc_err_i, frame_cnt_o, err_cnt_o.
module frx_stats
  import cdc_pkg::*;
(
  input  logic        clk_b,
  input  logic        rst_n,
  input  logic        inc_ok_i,
  input  logic        inc_err_i,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] err_cnt_o
);

  logic [15:0] frame_q, frame_d;
  logic [15:0] err_q, err_d;

  always_comb begin
    frame_d = frame_q;
    err_d   = err_q;
    if (inc_ok_i)
      frame_d = frame_q + 16'd1;
    if (inc_err_i && (err_q != 16'hFFFF))
      err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      err_q   <= '0;
    end else begin
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign frame_cnt_o = frame_q;
  assign err_cnt_o   = err_q;

endmodule

// File: rtl/cdc_frame_rx.sv
// cdc_frame_rx: clk_b deframer for SYNC, LEN, payload[LEN], CSUM.
// Ports: clk_b, rst_n, rx (slave): stream in; payload/status/stats out.
module cdc_frame_rx
  import cdc_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int               MAX_LEN   = MAX_LEN_DEF,
  parameter int               TIMEOUT   = TIMEOUT_DEF
) (
  input logic           clk_b,
  input logic           rst_n,
  cdc_frame_rx_if.slave rx
);

  if (WIDTH != 8 || MAX_LEN < 1 || MAX_LEN > 255 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_chk
    $error("cdc_frame_rx: illegal parameter value");
  end

  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  frx_state_t       state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      tmo_q, tmo_d;
  logic             pv_q, pv_d;
  logic [WIDTH-1:0] pd_q, pd_d;
  logic             pf_q, pf_d;
  logic             pl_q, pl_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  frx_err_t         err_q, err_d;

  logic             vld;
  logic [WIDTH-1:0] din;
  logic             expire;
  logic             inc_ok, inc_err;
  logic [15:0]      frame_cnt, err_cnt;

  assign vld = rx.data_valid_b;
  assign din = rx.data_b;

  // Idle limit reached this cycle; a byte arriving now takes priority.
  assign expire = (state_q != HUNT) && !vld &&
                  (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    pv_d    = 1'b0;
    pd_d    = pd_q;
    pf_d    = 1'b0;
    pl_d    = 1'b0;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    err_d   = ERR_NONE;
    if (state_q != HUNT)
      tmo_d = vld ? 16'd0 : tmo_q + 16'd1;
    unique case (state_q)
      HUNT: begin
        if (vld && din == SYNC_BYTE) begin
          state_d = LEN;
          cnt_d   = '0;
        end
      end
      LEN: begin
        if (vld) begin
          len_d = din;
          sum_d = din;
          cnt_d = '0;
          if (din == 8'd0) begin
            state_d = CSUM;
          end else if (din > MAX_LEN_B) begin
            state_d = HUNT;
            done_d  = 1'b1;
            err_d   = ERR_LEN;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (vld) begin
          pv_d  = 1'b1;
          pd_d  = din;
          pf_d  = (cnt_q == 8'd0);
          pl_d  = (cnt_q + 8'd1 == len_q);
          sum_d = sum_q + din;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q)
            state_d = CSUM;
        end
      end
      CSUM: begin
        if (vld) begin
          state_d = HUNT;
          done_d  = 1'b1;
          ok_d    = (din == sum_q);
          err_d   = (din == sum_q) ? ERR_NONE
                                   : ERR_CSUM;
        end
      end
    endcase
    if (expire) begin
      state_d = HUNT;
      done_d  = 1'b1;
      err_d   = ERR_TMO;
    end
    if (state_d == HUNT)
      tmo_d = '0;
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      len_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      pf_q    <= 1'b0;
      pl_q    <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      pf_q    <= pf_d;
      pl_q    <= pl_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // Counters see the event a cycle early so they move with frame_done.
  assign inc_ok  = done_d & ok_d;
  assign inc_err = done_d & ~ok_d;

  frx_stats u_stats (
    .clk_b       (clk_b),
    .rst_n       (rst_n),
    .inc_ok_i    (inc_ok),
    .inc_err_i   (inc_err),
    .frame_cnt_o (frame_cnt),
    .err_cnt_o   (err_cnt)
  );

  assign rx.pld_valid  = pv_q;
  assign rx.pld_data   = pd_q;
  assign rx.pld_first  = pf_q;
  assign rx.pld_last   = pl_q;
  assign rx.frame_done = done_q;
  assign rx.frame_ok   = ok_q;
  assign rx.frame_err  = err_q;
  assign rx.frame_cnt  = frame_cnt;
  assign rx.err_cnt    = err_cnt;

endmodule

// File: tb/tb_cdc_frame_rx.sv
// tb_cdc_frame_rx: scenario tasks for cdc_frame_rx against a frame-level model.
// Checksum covers LEN plus payload, modulo 256.
module tb_cdc_frame_rx;

  localparam int TMO  = 4;
  localparam int MAXL = 64;

  typedef struct packed {
    logic [7:0]  b;
    logic [31:0] c;
  } rec_t;

  typedef struct packed {
    logic [7:0]  d;
    logic        f;
    logic        l;
    logic [31:0] c;
  } pev_t;

  typedef struct packed {
    logic        ok;
    logic [1:0]  e;
    logic [31:0] c;
    logic [15:0] fc;
    logic [15:0] ec;
  } dev_t;

  logic        clk_b = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_fc = '0;
  logic [15:0] exp_ec = '0;
  pev_t        pq[$];
  pev_t        epq[$];
  dev_t        dq[$];
  dev_t        edq[$];

  always #4 clk_b = ~clk_b;
  always @(posedge clk_b) cyc <= cyc + 1;

  cdc_frame_rx_if #(.WIDTH(8)) bus ();

  cdc_frame_rx #(
    .WIDTH     (8),
    .SYNC_BYTE (8'hA5),
    .MAX_LEN   (MAXL),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_b (clk_b),
    .rst_n (rst_n),
    .rx    (bus)
  );

  // Monitor: every payload beat and frame end, stamped with cycle.
  always @(negedge clk_b) begin
    if (bus.pld_valid)
      pq.push_back('{bus.pld_data, bus.pld_first,
                     bus.pld_last, 32'(cyc)});
    if (bus.frame_done)
      dq.push_back('{bus.frame_ok, bus.frame_err, 32'(cyc),
                     bus.frame_cnt, bus.err_cnt});
  end

  task automatic send(input logic [7:0] b, output int c);
    @(negedge clk_b);
    bus.data_valid_b = 1'b1;
    bus.data_b       = b;
    c                = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_b);
      bus.data_valid_b = 1'b0;
      bus.data_b       = 8'h00;
    end
  endtask

  task automatic drive(input logic [7:0] b[$], input int maxgap,
                       output rec_t r[$]);
    int c;
    r = {};
    foreach (b[i]) begin
      idle(int'($urandom_range(maxgap)));
      send(b[i], c);
      r.push_back('{b[i], 32'(c)});
    end
  endtask

  // Frame-level reference: expected beats and outcome of one frame.
  function automatic void model_frame(input rec_t r[$]);
    logic [7:0] len;
    logic [7:0] ck;
    int         n;
    len = r[1].b;
    if (int'(len) > MAXL) begin
      if (exp_ec != 16'hFFFF) exp_ec++;
      edq.push_back('{1'b0, 2'd2, r[1].c + 32'd1, exp_fc, exp_ec});
      return;
    end
    n  = int'(len);
    ck = len;
    for (int i = 0; i < n; i++) begin
      ck = ck + r[2+i].b;
      epq.push_back('{r[2+i].b, i == 0, i == n - 1,
                      r[2+i].c + 32'd1});
    end
    if (r[2+n].b == ck) begin
      exp_fc++;
      edq.push_back('{1'b1, 2'd0, r[2+n].c + 32'd1, exp_fc, exp_ec});
    end else begin
      if (exp_ec != 16'hFFFF) exp_ec++;
      edq.push_back('{1'b0, 2'd1, r[2+n].c + 32'd1, exp_fc, exp_ec});
    end
  endfunction

  task automatic test_reset();
    bus.data_valid_b = 1'b0;
    bus.data_b       = 8'h00;
    rst_n            = 1'b0;
    for (int ph = 0; ph < 2; ph++) begin
      idle(3);
      n_chk++;
      if ({bus.pld_valid, bus.pld_data, bus.pld_first, bus.pld_last,
           bus.frame_done, bus.frame_ok, bus.frame_err,
           bus.frame_cnt, bus.err_cnt} !== 47'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d] got pv=%b pd=%h cnt=%h/%h want all 0",
                 ph, bus.pld_valid, bus.pld_data,
                 bus.frame_cnt, bus.err_cnt);
      end
      rst_n = 1'b1;
    end
  endtask

  task automatic test_directed();
    rec_t       r[$];
    logic [7:0] f[$];
    int         c;
    pq.delete(); dq.delete(); epq.delete(); edq.delete();
    f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    drive(f, 0, r); model_frame(r);
    f = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    drive(f, 0, r); model_frame(r);
    f = '{8'hA5, 8'h41};
    drive(f, 0, r); model_frame(r);
    f = '{8'hA5, 8'h00, 8'h00};
    drive(f, 0, r); model_frame(r);
    send(8'h00, c);
    send(8'hFF, c);
    f = '{8'hA5, 8'h01, 8'hA5, 8'hA6};
    drive(f, 0, r); model_frame(r);
    f = '{8'hA5, 8'h00, 8'h00};
    drive(f, 0, r); model_frame(r);
    idle(3);
    n_chk++;
    if (pq.size() != epq.size()) begin
      n_fail++;
      $display("FAIL dir_pld_count got %0d want %0d",
               pq.size(), epq.size());
    end
    for (int i = 0; i < pq.size() && i < epq.size(); i++) begin
      n_chk++;
      if (pq[i] !== epq[i]) begin
        n_fail++;
        $display("FAIL dir_pld[%0d] got d=%h f=%b l=%b cyc=%0d want d=%h f=%b l=%b cyc=%0d",
                 i, pq[i].d, pq[i].f, pq[i].l, pq[i].c,
                 epq[i].d, epq[i].f, epq[i].l, epq[i].c);
      end
    end
    n_chk++;
    if (dq.size() != edq.size()) begin
      n_fail++;
      $display("FAIL dir_done_count got %0d want %0d",
               dq.size(), edq.size());
    end
    for (int i = 0; i < dq.size() && i < edq.size(); i++) begin
      n_chk++;
      if (dq[i] !== edq[i]) begin
        n_fail++;
        $display("FAIL dir_done[%0d] got ok=%b err=%0d cyc=%0d fc=%0d ec=%0d want ok=%b err=%0d cyc=%0d fc=%0d ec=%0d",
                 i, dq[i].ok, dq[i].e, dq[i].c, dq[i].fc, dq[i].ec,
                 edq[i].ok, edq[i].e, edq[i].c, edq[i].fc, edq[i].ec);
      end
    end
  endtask

  task automatic test_timeout();
    int c, ca, cb, cs;
    dev_t wd;
    pev_t wp;
    pq.delete(); dq.delete();
    send(8'hA5, c);
    send(8'h02, c);
    send(8'hAA, ca);
    idle(TMO + 4);
    if (exp_ec != 16'hFFFF) exp_ec++;
    wp = '{8'hAA, 1'b1, 1'b0, 32'(ca + 1)};
    n_chk++;
    if (pq.size() != 1 || pq[0] !== wp) begin
      n_fail++;
      $display("FAIL tmo_partial got n=%0d d=%h l=%b want n=1 d=aa l=0",
               pq.size(), pq[0].d, pq[0].l);
    end
    wd = '{1'b0, 2'd3, 32'(ca + 1 + TMO), exp_fc, exp_ec};
    n_chk++;
    if (dq.size() != 1 || dq[0] !== wd) begin
      n_fail++;
      $display("FAIL tmo_done got n=%0d err=%0d cyc=%0d ec=%0d want n=1 err=3 cyc=%0d ec=%0d",
               dq.size(), dq[0].e, dq[0].c, dq[0].ec, wd.c, exp_ec);
    end
    pq.delete(); dq.delete();
    send(8'hA5, c);
    send(8'h02, c);
    send(8'hAA, ca);
    idle(TMO - 1);
    send(8'hBB, cb);
    send(8'h67, cs);
    idle(TMO + 3);
    exp_fc++;
    wd = '{1'b1, 2'd0, 32'(cs + 1), exp_fc, exp_ec};
    n_chk++;
    if (dq.size() != 1 || dq[0] !== wd) begin
      n_fail++;
      $display("FAIL tmo_byte_wins got n=%0d ok=%b err=%0d cyc=%0d want n=1 ok=1 err=0 cyc=%0d",
               dq.size(), dq[0].ok, dq[0].e, dq[0].c, wd.c);
    end
    wp = '{8'hBB, 1'b0, 1'b1, 32'(cb + 1)};
    n_chk++;
    if (pq.size() != 2 || pq[1] !== wp) begin
      n_fail++;
      $display("FAIL tmo_byte_wins_pld got n=%0d d=%h l=%b want n=2 d=bb l=1",
               pq.size(), pq[1].d, pq[1].l);
    end
  endtask

  task automatic test_random();
    rec_t r[$];
    int   c;
    pq.delete(); dq.delete(); epq.delete(); edq.delete();
    for (int k = 0; k < 30; k++) begin
      logic [7:0] f[$];
      logic [7:0] b;
      logic [7:0] ck;
      int         len;
      int         sel;
      repeat ($urandom_range(2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send(b, c);
      end
      sel = int'($urandom_range(5));
      if (k == 0)        len = MAXL;
      else if (k == 1)   len = MAXL + 1;
      else if (sel == 0) len = int'($urandom_range(255, MAXL + 1));
      else if (sel == 1) len = 0;
      else               len = int'($urandom_range(12, 1));
      f = {};
      f.push_back(8'hA5);
      f.push_back(8'(len));
      if (len <= MAXL) begin
        ck = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          f.push_back(b);
          ck = ck + b;
        end
        if ($urandom_range(3) == 0)
          ck = ck ^ 8'($urandom_range(255, 1));
        f.push_back(ck);
      end
      drive(f, TMO - 1, r);
      model_frame(r);
    end
    idle(4);
    n_chk++;
    if (pq.size() != epq.size()) begin
      n_fail++;
      $display("FAIL rnd_pld_count got %0d want %0d",
               pq.size(), epq.size());
    end
    for (int i = 0; i < pq.size() && i < epq.size(); i++) begin
      n_chk++;
      if (pq[i] !== epq[i]) begin
        n_fail++;
        $display("FAIL rnd_pld[%0d] got d=%h f=%b l=%b cyc=%0d want d=%h f=%b l=%b cyc=%0d",
                 i, pq[i].d, pq[i].f, pq[i].l, pq[i].c,
                 epq[i].d, epq[i].f, epq[i].l, epq[i].c);
      end
    end
    n_chk++;
    if (dq.size() != edq.size()) begin
      n_fail++;
      $display("FAIL rnd_done_count got %0d want %0d",
               dq.size(), edq.size());
    end
    for (int i = 0; i < dq.size() && i < edq.size(); i++) begin
      n_chk++;
      if (dq[i] !== edq[i]) begin
        n_fail++;
        $display("FAIL rnd_done[%0d] got ok=%b err=%0d cyc=%0d fc=%0d ec=%0d want ok=%b err=%0d cyc=%0d fc=%0d ec=%0d",
                 i, dq[i].ok, dq[i].e, dq[i].c, dq[i].fc, dq[i].ec,
                 edq[i].ok, edq[i].e, edq[i].c, edq[i].fc, edq[i].ec);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   c, cs;
    dev_t wd;
    send(8'hA5, c);
    send(8'h05, c);
    send(8'h01, c);
    send(8'h02, c);
    @(negedge clk_b);
    n_chk++;
    if (bus.pld_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre got pld_valid=%b want 1", bus.pld_valid);
    end
    dq.delete();
    rst_n            = 1'b0;
    bus.data_valid_b = 1'b0;
    #1;
    n_chk++;
    if ({bus.pld_valid, bus.pld_data, bus.pld_first, bus.pld_last,
         bus.frame_done, bus.frame_ok, bus.frame_err,
         bus.frame_cnt, bus.err_cnt} !== 47'd0) begin
      n_fail++;
      $display("FAIL rstmid_async got pv=%b pd=%h fd=%b cnt=%h/%h want all 0",
               bus.pld_valid, bus.pld_data, bus.frame_done,
               bus.frame_cnt, bus.err_cnt);
    end
    idle(2);
    rst_n  = 1'b1;
    exp_fc = '0;
    exp_ec = '0;
    idle(TMO + 3);
    n_chk++;
    if (dq.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_done got %0d events want 0", dq.size());
    end
    send(8'hA5, c);
    send(8'h01, c);
    send(8'h7E, c);
    send(8'h7F, cs);
    idle(3);
    exp_fc++;
    wd = '{1'b1, 2'd0, 32'(cs + 1), exp_fc, exp_ec};
    n_chk++;
    if (dq.size() != 1 || dq[0] !== wd) begin
      n_fail++;
      $display("FAIL rstmid_after got n=%0d ok=%b fc=%0d ec=%0d want n=1 ok=1 fc=1 ec=0",
               dq.size(), dq[0].ok, dq[0].fc, dq[0].ec);
    end
  endtask

  task automatic test_saturation();
    int c;
    @(negedge clk_b);
    force dut.u_stats.err_q = 16'hFFFF;
    @(negedge clk_b);
    release dut.u_stats.err_q;
    @(negedge clk_b);
    exp_ec = 16'hFFFF;
    n_chk++;
    if (bus.err_cnt !== exp_ec) begin
      n_fail++;
      $display("FAIL sat_preset got %h want ffff", bus.err_cnt);
    end
    dq.delete();
    send(8'hA5, c);
    send(8'h01, c);
    send(8'h00, c);
    send(8'h00, c);
    idle(3);
    n_chk++;
    if (dq.size() != 1 || dq[0].ok !== 1'b0 || dq[0].e !== 2'd1 ||
        dq[0].ec !== exp_ec || dq[0].fc !== exp_fc) begin
      n_fail++;
      $display("FAIL sat_bad_frame got n=%0d ok=%b err=%0d ec=%h fc=%0d want n=1 ok=0 err=1 ec=ffff fc=%0d",
               dq.size(), dq[0].ok, dq[0].e, dq[0].ec, dq[0].fc, exp_fc);
    end
    n_chk++;
    if (bus.err_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold got %h want ffff", bus.err_cnt);
    end
  endtask

  initial begin
    bus.data_valid_b = 1'b0;
    bus.data_b       = 8'h00;
    test_reset();
    test_directed();
    test_timeout();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
